// File: rtl/loopback_mux_gbe_ovf_monitor.sv
// GbE TX overflow status capture: sticky flag, saturating event count, longest run
// and phase state, packed into the 32-bit word feeding the status register.
module loopback_mux_gbe_ovf_monitor #(
  parameter int EVENT_CNT_W = 12,
  parameter int RUN_W       = 16
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        gbe_tx_overflow,
  input  logic        stat_clr,
  output logic [31:0] user_data_out,
  output logic        ovf_sticky
);

  localparam logic [1:0] ST_CLEAR    = 2'b00;
  localparam logic [1:0] ST_IDLE     = 2'b01;
  localparam logic [1:0] ST_IN_OVF   = 2'b10;
  localparam logic [1:0] ST_POST_OVF = 2'b11;

  logic                   ovf_q;
  logic                   clr_q;
  logic                   clr_qq;
  logic                   clr_p;
  logic [1:0]             state;
  logic [1:0]             state_n;
  logic [EVENT_CNT_W-1:0] evt_cnt;
  logic [EVENT_CNT_W-1:0] evt_n;
  logic [RUN_W-1:0]       run_cnt;
  logic [RUN_W-1:0]       run_n;
  logic [RUN_W-1:0]       max_run;
  logic [RUN_W-1:0]       max_n;
  logic                   sticky;
  logic                   sticky_n;

  function automatic logic [EVENT_CNT_W-1:0] sat_inc_evt(input logic [EVENT_CNT_W-1:0] v);
    return (&v) ? v : v + EVENT_CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  // Stage 1: input registers and clear edge detect
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      ovf_q  <= 1'b0;
      clr_q  <= 1'b0;
      clr_qq <= 1'b0;
    end else begin
      ovf_q  <= gbe_tx_overflow;
      clr_q  <= stat_clr;
      clr_qq <= clr_q;
    end
  end

  assign clr_p = clr_q & ~clr_qq;

  always_comb begin
    state_n  = state;
    evt_n    = evt_cnt;
    run_n    = run_cnt;
    sticky_n = sticky;
    if (clr_p) begin
      state_n  = ST_CLEAR;
      evt_n    = '0;
      run_n    = '0;
      sticky_n = 1'b0;
    end else begin
      case (state)
        ST_IN_OVF: begin
          if (ovf_q) run_n   = sat_inc_run(run_cnt);
          else       state_n = ST_POST_OVF;
        end
        default: begin
          // CLEAR, IDLE and POST_OVF all start a new run the same way
          if (ovf_q) begin
            state_n  = ST_IN_OVF;
            evt_n    = sat_inc_evt(evt_cnt);
            run_n    = RUN_W'(1);
            sticky_n = 1'b1;
          end else if (state == ST_CLEAR) begin
            state_n = ST_IDLE;
          end
        end
      endcase
    end
    // Compare against the next run value so max_run moves on the same edge as run_cnt
    if (clr_p)                 max_n = '0;
    else if (run_n > max_run)  max_n = run_n;
    else                       max_n = max_run;
  end

  // Stage 2: state and statistics
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state   <= ST_CLEAR;
      evt_cnt <= '0;
      run_cnt <= '0;
      max_run <= '0;
      sticky  <= 1'b0;
    end else begin
      state   <= state_n;
      evt_cnt <= evt_n;
      run_cnt <= run_n;
      max_run <= max_n;
      sticky  <= sticky_n;
    end
  end

  // Stage 3: packed status word, all fields update together
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) user_data_out <= 32'h0000_0000;
    else             user_data_out <= {sticky, ovf_q, state, evt_cnt, max_run};
  end

  assign ovf_sticky = user_data_out[31];

endmodule

// File: tb/tb_loopback_mux_gbe_ovf_monitor.sv
// Bench for loopback_mux_gbe_ovf_monitor: directed vector table, corner-case
// sequences and random stimulus, all compared against a behavioural model.
module tb_loopback_mux_gbe_ovf_monitor;

  localparam int EVT_MAX = 4095;
  localparam int RUN_MAX = 65535;

  logic        user_clk = 1'b0;
  logic        user_rst_n = 1'b0;
  logic        gbe_tx_overflow = 1'b0;
  logic        stat_clr = 1'b0;
  logic [31:0] user_data_out;
  logic        ovf_sticky;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  loopback_mux_gbe_ovf_monitor #(.EVENT_CNT_W(12), .RUN_W(16)) dut (
    .user_clk        (user_clk),
    .user_rst_n      (user_rst_n),
    .gbe_tx_overflow (gbe_tx_overflow),
    .stat_clr        (stat_clr),
    .user_data_out   (user_data_out),
    .ovf_sticky      (ovf_sticky)
  );

  always #5 user_clk = ~user_clk;

  // Behavioural model: phase flags and plain integer statistics
  bit          q_ovf, q_clr, q_clrq;
  bit          m_clear, m_active, m_seen;
  int          m_evt, m_run, m_max;
  logic [31:0] exp_word = 32'h0;

  always @(posedge user_clk) begin
    bit         clr_now;
    logic [1:0] st;
    if (!user_rst_n) begin
      q_ovf = 0; q_clr = 0; q_clrq = 0;
      m_clear = 1; m_active = 0; m_seen = 0;
      m_evt = 0; m_run = 0; m_max = 0;
      exp_word = 32'h0;
    end else begin
      st = m_clear ? 2'd0 : m_active ? 2'd2 : m_seen ? 2'd3 : 2'd1;
      exp_word = {m_seen, q_ovf, st, 12'(m_evt), 16'(m_max)};
      clr_now = q_clr && !q_clrq;
      if (clr_now) begin
        m_clear = 1; m_active = 0; m_seen = 0;
        m_evt = 0; m_run = 0; m_max = 0;
      end else begin
        m_clear = 0;
        if (q_ovf && !m_active) begin
          m_evt = (m_evt < EVT_MAX) ? m_evt + 1 : EVT_MAX;
          m_run = 1;
          m_active = 1;
          m_seen = 1;
        end else if (q_ovf) begin
          m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
        end else begin
          m_active = 0;
        end
        if (m_run > m_max) m_max = m_run;
      end
      q_clrq = q_clr;
      q_clr  = stat_clr;
      q_ovf  = gbe_tx_overflow;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge user_clk) begin
    if (mon_en) begin
      chk("model_word", user_data_out, exp_word);
      chk("model_sticky", {31'b0, ovf_sticky}, {31'b0, exp_word[31]});
    end
  end

  task automatic hold(input logic o, input int n);
    gbe_tx_overflow = o;
    repeat (n) @(negedge user_clk);
  endtask

  task automatic do_clear();
    stat_clr = 1'b1;
    repeat (2) @(negedge user_clk);
    stat_clr = 1'b0;
    @(negedge user_clk);
  endtask

  typedef struct {
    bit          clr;
    int          hi;
    int          lo;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n_clear;
    logic [31:0] clr_word;

    vecs[0] = '{1, 7, 5, 32'hB001_0007};
    vecs[1] = '{0, 3, 4, 32'hB002_0007};
    vecs[2] = '{0, 9, 4, 32'hB003_0009};
    vecs[3] = '{0, 1, 4, 32'hB004_0009};
    vecs[4] = '{1, 0, 6, 32'h1000_0000};
    vecs[5] = '{0, 1, 4, 32'hB001_0001};
    vecs[6] = '{1, 2, 4, 32'hB001_0002};

    // Reset hold and release with overflow low
    repeat (2) @(negedge user_clk);
    mon_en = 1'b1;
    repeat (3) @(negedge user_clk);
    chk("reset_word", user_data_out, 32'h0);
    chk("reset_sticky", {31'b0, ovf_sticky}, 32'h0);
    user_rst_n = 1'b1;
    repeat (3) @(negedge user_clk);
    chk("idle_after_reset", user_data_out, 32'h1000_0000);
    repeat (5) @(negedge user_clk);
    chk("idle_stays", user_data_out, 32'h1000_0000);

    // Directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      if (vecs[i].hi > 0) hold(1'b1, vecs[i].hi);
      hold(1'b0, vecs[i].lo);
      chk($sformatf("vec%0d", i), user_data_out, vecs[i].word);
    end

    // Event counter saturation
    do_clear();
    for (int i = 0; i < 4100; i++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 4);
    chk("evt_saturate", user_data_out, 32'hBFFF_0001);

    // Run length saturation
    do_clear();
    hold(1'b1, 65540);
    chk("run_saturate_live", user_data_out, 32'hE001_FFFF);
    hold(1'b0, 4);
    chk("run_saturate_end", user_data_out, 32'hB001_FFFF);

    // Clear during an active overflow, clear input held high
    hold(1'b1, 6);
    stat_clr = 1'b1;
    n_clear = 0;
    clr_word = 32'hFFFF_FFFF;
    for (int i = 0; i < 12; i++) begin
      @(negedge user_clk);
      if (user_data_out[29:28] == 2'b00) begin
        n_clear++;
        clr_word = user_data_out;
      end
    end
    chk("clear_once", 32'(n_clear), 32'd1);
    chk("clear_word", clr_word, 32'h4000_0000);
    chk("after_clear_hi", {16'h0, user_data_out[31:16]}, 32'h0000_E001);
    stat_clr = 1'b0;
    hold(1'b1, 2);

    // Reset in the middle of a run, overflow still high afterwards
    user_rst_n = 1'b0;
    @(negedge user_clk);
    for (int i = 0; i < 3; i++) begin
      chk("mid_reset_word", user_data_out, 32'h0);
      chk("mid_reset_sticky", {31'b0, ovf_sticky}, 32'h0);
      @(negedge user_clk);
    end
    user_rst_n = 1'b1;
    hold(1'b1, 6);
    chk("after_reset_hi", {16'h0, user_data_out[31:16]}, 32'h0000_E001);
    hold(1'b0, 4);

    // Random overflow and clear activity
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0)  gbe_tx_overflow = ~gbe_tx_overflow;
      if ($urandom_range(0, 25) == 0) stat_clr = ~stat_clr;
      @(negedge user_clk);
    end
    hold(1'b0, 5);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
